// File: rtl/fetch_instr_queue.sv
// Decoupling FIFO between the fetch unit and the back end. Each entry holds
// one fetched bundle: PC, instruction, predicted target, predicted-taken flag
// and fetch exception. Adds flush, occupancy reporting and an exception fence
// that stops further fetch pushes once a faulting bundle has been queued.
module fetch_instr_queue #(
    parameter int XLEN     = 64,
    parameter int ILEN     = 32,
    parameter int EXCW     = 4,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       fetch_valid_i,
    output logic                       fetch_ready_o,
    input  logic [XLEN-1:0]            curr_pc_i,
    input  logic [ILEN-1:0]            instruction_i,
    input  logic [XLEN-1:0]            pred_target_i,
    input  logic                       pred_taken_i,
    input  logic                       except_raised_i,
    input  logic [EXCW-1:0]            except_code_i,
    output logic                       be_valid_o,
    input  logic                       be_ready_i,
    output logic [XLEN-1:0]            be_pc_o,
    output logic [ILEN-1:0]            be_instruction_o,
    output logic [XLEN-1:0]            be_pred_target_o,
    output logic                       be_pred_taken_o,
    output logic                       be_except_raised_o,
    output logic [EXCW-1:0]            be_except_code_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       fenced_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = XLEN + ILEN + XLEN + 2 + EXCW;

    logic [BW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          fenced_q;
    logic [BW-1:0] hold_q;
    logic [BW-1:0] wr_data;
    logic [BW-1:0] head;
    logic          push;
    logic          pop;

    // Pointers wrap explicitly so DEPTH does not have to be a power of two
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on registered state, never on be_ready_i
    assign fetch_ready_o = (count_q < CW'(DEPTH)) && !fenced_q;
    assign be_valid_o    = (count_q != '0);
    assign push          = fetch_valid_i && fetch_ready_o;
    assign pop           = be_valid_o && be_ready_i;

    assign wr_data = {curr_pc_i, instruction_i, pred_target_i,
                      pred_taken_i, except_raised_i, except_code_i};

    // While empty, present the last head seen so the data outputs stay stable
    assign head = be_valid_o ? mem[rd_ptr_q] : hold_q;
    assign {be_pc_o, be_instruction_o, be_pred_target_o,
            be_pred_taken_o, be_except_raised_o, be_except_code_o} = head;

    assign count_o       = count_q;
    assign almost_full_o = (count_q >= CW'(AFULL_TH));
    assign fenced_o      = fenced_q;

    // Storage write; a flush or reset in the same cycle discards the push
    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !flush_i) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointer, occupancy, fence and held-output state; reset beats flush beats handshakes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fenced_q <= 1'b0;
            hold_q   <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fenced_q <= 1'b0;
        end else begin
            if (be_valid_o) begin
                hold_q <= mem[rd_ptr_q];
            end
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
                if (except_raised_i) begin
                    fenced_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Directed bench for fetch_instr_queue. Two instances (DEPTH=4 and DEPTH=3)
// share the same inputs; use3 selects which one is compared against the
// reference model (occupancy, fence and a queue of expected bundles).
module tb_fetch_instr_queue;

    logic clk = 1'b0;

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        fetch_valid;
    logic [63:0] curr_pc;
    logic [31:0] instruction;
    logic [63:0] pred_target;
    logic        pred_taken;
    logic        except_raised;
    logic [3:0]  except_code;
    logic        be_ready;

    logic        r4, v4, tk4, ex4, af4, fn4;
    logic [63:0] pc4, tg4;
    logic [31:0] in4;
    logic [3:0]  cd4;
    logic [2:0]  cnt4;

    logic        r3, v3, tk3, ex3, af3, fn3;
    logic [63:0] pc3, tg3;
    logic [31:0] in3;
    logic [3:0]  cd3;
    logic [1:0]  cnt3;

    logic        o_ready, o_valid, o_taken, o_exc, o_afull, o_fenced;
    logic [63:0] o_pc, o_target;
    logic [31:0] o_instr;
    logic [3:0]  o_code;
    logic [2:0]  o_count;

    logic use3;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] target;
        logic        taken;
        logic        exc;
        logic [3:0]  code;
    } bundle_t;

    bundle_t sb[$];
    int      m_count;
    logic    m_fenced;
    int      errors = 0;
    int      checks = 0;

    fetch_instr_queue dut4 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fetch_valid_i(fetch_valid), .fetch_ready_o(r4),
        .curr_pc_i(curr_pc), .instruction_i(instruction),
        .pred_target_i(pred_target), .pred_taken_i(pred_taken),
        .except_raised_i(except_raised), .except_code_i(except_code),
        .be_valid_o(v4), .be_ready_i(be_ready),
        .be_pc_o(pc4), .be_instruction_o(in4),
        .be_pred_target_o(tg4), .be_pred_taken_o(tk4),
        .be_except_raised_o(ex4), .be_except_code_o(cd4),
        .count_o(cnt4), .almost_full_o(af4), .fenced_o(fn4)
    );

    fetch_instr_queue #(.DEPTH(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .fetch_valid_i(fetch_valid), .fetch_ready_o(r3),
        .curr_pc_i(curr_pc), .instruction_i(instruction),
        .pred_target_i(pred_target), .pred_taken_i(pred_taken),
        .except_raised_i(except_raised), .except_code_i(except_code),
        .be_valid_o(v3), .be_ready_i(be_ready),
        .be_pc_o(pc3), .be_instruction_o(in3),
        .be_pred_target_o(tg3), .be_pred_taken_o(tk3),
        .be_except_raised_o(ex3), .be_except_code_o(cd3),
        .count_o(cnt3), .almost_full_o(af3), .fenced_o(fn3)
    );

    // Route the selected instance's outputs to the comparison points
    always_comb begin
        o_ready  = use3 ? r3  : r4;
        o_valid  = use3 ? v3  : v4;
        o_pc     = use3 ? pc3 : pc4;
        o_instr  = use3 ? in3 : in4;
        o_target = use3 ? tg3 : tg4;
        o_taken  = use3 ? tk3 : tk4;
        o_exc    = use3 ? ex3 : ex4;
        o_code   = use3 ? cd3 : cd4;
        o_count  = use3 ? {1'b0, cnt3} : cnt4;
        o_afull  = use3 ? af3 : af4;
        o_fenced = use3 ? fn3 : fn4;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int depth;
        depth = use3 ? 3 : 4;
        chk("fetch_ready", 128'(o_ready), 128'((m_count < depth) && !m_fenced));
        chk("be_valid", 128'(o_valid), 128'(m_count != 0));
        chk("count", 128'(o_count), 128'(m_count));
        chk("almost_full", 128'(o_afull), 128'(m_count >= depth - 1));
        chk("fenced", 128'(o_fenced), 128'(m_fenced));
    endtask

    task automatic checkResetData();
        #1;
        chk("rst_pc", 128'(o_pc), 128'(0));
        chk("rst_instr", 128'(o_instr), 128'(0));
        chk("rst_target", 128'(o_target), 128'(0));
        chk("rst_flags", 128'({o_taken, o_exc, o_code}), 128'(0));
    endtask

    task automatic applyStimulus(input logic fv, input logic [63:0] pc, input logic [31:0] ins,
                                 input logic exc, input logic [3:0] code,
                                 input logic br, input logic fl, input logic rs);
        bundle_t b;
        bundle_t h;
        logic    push;
        logic    pop;
        int      depth;
        @(negedge clk);
        fetch_valid   = fv;
        curr_pc       = pc;
        instruction   = ins;
        pred_target   = pc + 64'h100;
        pred_taken    = pc[2];
        except_raised = exc;
        except_code   = code;
        be_ready      = br;
        flush         = fl;
        rst           = rs;
        #1;
        checkOutput();
        depth = use3 ? 3 : 4;
        push  = fv && (m_count < depth) && !m_fenced;
        pop   = (m_count != 0) && br;
        if (pop && !rs && !fl) begin
            h = sb[0];
            chk("head_pc", 128'(o_pc), 128'(h.pc));
            chk("head_instr", 128'(o_instr), 128'(h.instr));
            chk("head_meta", {57'd0, o_target, o_taken, o_exc, o_code},
                             {57'd0, h.target, h.taken, h.exc, h.code});
        end
        @(posedge clk);
        if (rs || fl) begin
            sb.delete();
            m_fenced = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                b.pc     = pc;
                b.instr  = ins;
                b.target = pc + 64'h100;
                b.taken  = pc[2];
                b.exc    = exc;
                b.code   = code;
                sb.push_back(b);
                if (exc) m_fenced = 1'b1;
            end
        end
        m_count = sb.size();
    endtask

    task automatic pushPc(input logic [63:0] pc, input logic br);
        applyStimulus(1'b1, pc, 32'hA000_0000 | pc[31:0], 1'b0, 4'h0, br, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic br);
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 4'h0, br, 1'b0, 1'b0);
    endtask

    // Directed sequence covering fill, full-pop, latency, fence, flush, wrap and reset
    initial begin
        use3 = 1'b0;
        rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; be_ready = 1'b0;
        curr_pc = '0; instruction = '0; pred_target = '0; pred_taken = 1'b0;
        except_raised = 1'b0; except_code = '0;
        m_count = 0; m_fenced = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0);
        checkResetData();

        $display("[TB] fill to full with back end stalled");
        for (int i = 0; i < 4; i++) pushPc(64'(i * 4), 1'b0);
        pushPc(64'h10, 1'b1);
        pushPc(64'h10, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        $display("[TB] push into empty queue with back end ready");
        applyStimulus(1'b1, 64'h40, 32'h0000_0013, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] exception fence");
        pushPc(64'h20, 1'b0);
        applyStimulus(1'b1, 64'h24, 32'hA000_0024, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        pushPc(64'h28, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        pushPc(64'h2C, 1'b0);
        idle(1'b0);

        $display("[TB] flush with concurrent push and pop");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        pushPc(64'h50, 1'b0);
        pushPc(64'h54, 1'b0);
        pushPc(64'h58, 1'b0);
        applyStimulus(1'b1, 64'h5C, 32'hA000_005C, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        pushPc(64'h60, 1'b0);
        idle(1'b1);
        idle(1'b0);

        $display("[TB] depth 3 wrap and mid-stream reset");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        use3 = 1'b1;
        idle(1'b0);
        checkResetData();
        pushPc(64'h100, 1'b0);
        pushPc(64'h104, 1'b0);
        for (int k = 0; k < 10; k++) pushPc(64'h108 + 64'(k * 4), 1'b1);
        pushPc(64'h200, 1'b0);
        pushPc(64'h204, 1'b1);
        idle(1'b1);
        applyStimulus(1'b1, 64'h300, 32'hA000_0300, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        checkResetData();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Parametrised decoupling buffer between the fetch unit and the back end.
- Stores fetched instruction bundles: PC, instruction, predicted target, predicted-taken flag and fetch exception.
- Replaces the direct fetch-to-back-end valid/ready connection with a DEPTH-entry FIFO.
- Adds flush, occupancy reporting and exception fencing, which the direct connection lacks.

Parameters:
- XLEN, 64, PC and predicted-target width
- ILEN, 32, instruction width
- EXCW, 4, exception code width
- DEPTH, 4, number of entries; any integer >= 2
- AFULL_TH, DEPTH-1, occupancy at or above which almost_full_o asserts

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- flush_i  in  1  synchronous flush; discards all entries
- fetch_valid_i  in  1  fetch bundle valid
- fetch_ready_o  out  1  queue can accept a bundle
- curr_pc_i  in  XLEN  bundle PC
- instruction_i  in  ILEN  bundle instruction
- pred_target_i  in  XLEN  predicted target
- pred_taken_i  in  1  predicted taken
- except_raised_i  in  1  fetch exception flag
- except_code_i  in  EXCW  fetch exception code
- be_valid_o  out  1  head entry valid toward the back end
- be_ready_i  in  1  back end accepts the head entry
- be_pc_o  out  XLEN  head PC
- be_instruction_o  out  ILEN  head instruction
- be_pred_target_o  out  XLEN  head predicted target
- be_pred_taken_o  out  1  head predicted-taken flag
- be_except_raised_o  out  1  head exception flag
- be_except_code_o  out  EXCW  head exception code
- count_o  out  $clog2(DEPTH+1)  current occupancy
- almost_full_o  out  1  count_o >= AFULL_TH
- fenced_o  out  1  exception entry accepted; further pushes blocked

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - count=0; read and write pointers=0; fenced=0.
  - Outputs: fetch_ready_o=1, be_valid_o=0, count_o=0, almost_full_o=0, fenced_o=0.
  - All be_*_o data outputs=0; storage array need not be cleared.
  - Reset has priority over flush and over any handshake in the same cycle.
- Push: occurs when fetch_valid_i && fetch_ready_o. Bundle is written at the write pointer; the write pointer advances.
- fetch_ready_o = (count < DEPTH) && !fenced. It is registered-state only and has no combinational path from be_ready_i.
- Pop: occurs when be_valid_o && be_ready_i. The read pointer advances.
- be_valid_o = (count != 0).
- be_*_o data outputs:
  - Driven combinationally from the entry at the read pointer.
  - Hold their last value when the queue is empty; they are don't-care while be_valid_o=0.
- Latency: no bypass. A bundle pushed at edge N is visible on be_*_o with be_valid_o=1 after edge N, i.e. 1 cycle.
- Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of 2.
- Count update per edge: +1 on push only; -1 on pop only; unchanged when push and pop occur together or when neither occurs.
- Full (count=DEPTH): fetch_ready_o=0. A pop in that cycle does not enable a push in the same cycle; the push is accepted in the next cycle.
- Empty (count=0): a push and a back-end ready in the same cycle do not pop; the entry appears next cycle.
- Exception fence:
  - Pushing a bundle with except_raised_i=1 sets fenced=1 at that edge.
  - That bundle itself is stored.
  - While fenced=1, fetch_ready_o=0 regardless of space.
  - fenced clears only on flush or reset. Draining the queue does not clear it.
- Flush (flush_i=1, rst_i=0):
  - At the edge: count=0, both pointers=0, fenced=0.
  - A push or pop in the same cycle is discarded and has no effect.
  - be_valid_o=0 from the next cycle.
  - fetch_ready_o=1 in the cycle after flush.
  - During the flush cycle itself, fetch_ready_o reflects pre-flush state.
- Reset or flush mid-operation: any queued bundles are lost; no partial state survives.
- almost_full_o = (count >= AFULL_TH), derived from registered count.

Test Plan:
- Reset, then push PCs 0x0, 0x4, 0x8, 0xC with be_ready_i=0, DEPTH=4 -> count_o=4, fetch_ready_o=0, almost_full_o=1 from count 3; be_pc_o=0x0.
- Queue full; hold fetch_valid_i=1 with PC 0x10 and raise be_ready_i for 1 cycle -> PC 0x0 popped that cycle; 0x10 accepted next cycle; final order 0x4, 0x8, 0xC, 0x10.
- Empty queue; push instruction 0x00000013 with be_ready_i=1 -> be_valid_o=1 exactly 1 cycle later with be_instruction_o=0x00000013; count_o returns to 0 after the pop.
- Push PC 0x20 (no exception), PC 0x24 with except_raised_i=1 and code 0x1, then PC 0x28 -> 0x28 is not accepted; fenced_o=1; after draining, count_o=0, fenced_o=1, fetch_ready_o=0.
- With 3 entries queued, assert flush_i together with a push and be_ready_i -> next cycle count_o=0, be_valid_o=0, fenced_o=0, fetch_ready_o=1; the pushed bundle is never output.
- DEPTH=3: perform 10 interleaved push/pop pairs -> pointers wrap; output order equals input order; count_o never exceeds 3; assert rst_i mid-stream -> all outputs return to reset values next cycle.
